// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI4 memory slave: response codes,
// channel FSM states and the burst legality check used by both address channels.
package axi_slave_pkg;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_SLVERR    = 2'b10;
   localparam int         BOUNDARY_BYTES = 4096;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // A burst is rejected when it runs past the last word, crosses a 4 KB page,
   // or asks for beats wider than the data bus. Sums are wide enough not to wrap.
   function automatic logic burst_err(input logic [31:0] addr,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size,
                                      input int          addr_lsb,
                                      input int          depth);
      logic [32:0] w_end;
      logic [31:0] w_span;
      w_end  = {1'b0, addr >> addr_lsb} + 33'(len) + 33'd1;
      w_span = {20'd0, addr[11:0]} + ((32'(len) + 32'd1) << size);
      return ({29'd0, size} > 32'(addr_lsb)) ||
             (w_end > 33'(depth)) ||
             (w_span > 32'(BOUNDARY_BYTES));
   endfunction

endpackage

// File: rtl/axi4_slave_ram.sv
// Simple dual-port word RAM: one write port, one registered read port.
// A read and write to the same word in one cycle returns the old contents.
module axi4_slave_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // NOTE: the storage array has no reset so it maps onto RAM macros/BRAM;
   // only the read-data register is reset.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // NOTE: non-blocking assignments here are what give read-before-write
   // when both ports hit the same word on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write and read channel FSMs
// in front of a dual-port word RAM; illegal bursts are drained and answered SLVERR.
module axi4_mem_slave
   import axi_slave_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int MEMORY_DEPTH = 1024
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [7:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  WVALID,
   input  logic                  WLAST,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [7:0]            ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W    = $clog2(MEMORY_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   // ---------------- write channel ----------------
   w_state_t              r_w_state, w_w_state_nx;
   logic                  r_awready, w_awready_nx;
   logic                  r_wready,  w_wready_nx;
   logic                  r_bvalid,  w_bvalid_nx;
   logic [1:0]            r_bresp,   w_bresp_nx;
   logic [ADDR_WIDTH-1:0] r_waddr,   w_waddr_nx;
   logic [7:0]            r_wlen,    w_wlen_nx;
   logic [2:0]            r_wsize,   w_wsize_nx;
   logic [7:0]            r_wcnt,    w_wcnt_nx;
   logic                  r_werr,    w_werr_nx;
   logic                  r_wlast_err, w_wlast_err_nx;
   logic                  w_aw_err, w_wbeat, w_mem_we;

   assign w_aw_err = burst_err(32'(AWADDR), AWLEN, AWSIZE, ADDR_LSB, MEMORY_DEPTH);
   assign w_wbeat  = WVALID && r_wready;
   assign w_mem_we = (r_w_state == W_DATA) && w_wbeat && !r_werr;

   // NOTE: every next-value defaults to its current register first so no
   // path through the case leaves a signal unassigned (no latches).
   always_comb begin
      w_w_state_nx    = r_w_state;
      w_awready_nx    = r_awready;
      w_wready_nx     = r_wready;
      w_bvalid_nx     = r_bvalid;
      w_bresp_nx      = r_bresp;
      w_waddr_nx      = r_waddr;
      w_wlen_nx       = r_wlen;
      w_wsize_nx      = r_wsize;
      w_wcnt_nx       = r_wcnt;
      w_werr_nx       = r_werr;
      w_wlast_err_nx  = r_wlast_err;
      case (r_w_state)
         W_IDLE: begin
            w_awready_nx = 1'b1;
            if (AWVALID && r_awready) begin
               w_waddr_nx     = AWADDR;
               w_wlen_nx      = AWLEN;
               w_wsize_nx     = AWSIZE;
               w_werr_nx      = w_aw_err;
               w_wcnt_nx      = 8'd0;
               w_wlast_err_nx = 1'b0;
               w_awready_nx   = 1'b0;
               w_wready_nx    = 1'b1;
               w_w_state_nx   = W_DATA;
            end
         end
         W_DATA: begin
            if (w_wbeat) begin
               w_wcnt_nx  = r_wcnt + 8'd1;
               w_waddr_nx = r_waddr + (ONE << r_wsize);
               if (r_wcnt == r_wlen) begin
                  w_wready_nx  = 1'b0;
                  w_bvalid_nx  = 1'b1;
                  w_bresp_nx   = (r_werr || r_wlast_err || !WLAST) ? RESP_SLVERR : RESP_OKAY;
                  w_w_state_nx = W_RESP;
               end else if (WLAST) begin
                  w_wlast_err_nx = 1'b1;
               end
            end
         end
         W_RESP: begin
            if (BREADY && r_bvalid) begin
               w_bvalid_nx  = 1'b0;
               w_bresp_nx   = RESP_OKAY;
               w_awready_nx = 1'b1;
               w_w_state_nx = W_IDLE;
            end
         end
         default: w_w_state_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_w_state   <= W_IDLE;
         r_awready   <= 1'b0;
         r_wready    <= 1'b0;
         r_bvalid    <= 1'b0;
         r_bresp     <= RESP_OKAY;
         r_waddr     <= '0;
         r_wlen      <= '0;
         r_wsize     <= '0;
         r_wcnt      <= '0;
         r_werr      <= 1'b0;
         r_wlast_err <= 1'b0;
      end else begin
         r_w_state   <= w_w_state_nx;
         r_awready   <= w_awready_nx;
         r_wready    <= w_wready_nx;
         r_bvalid    <= w_bvalid_nx;
         r_bresp     <= w_bresp_nx;
         r_waddr     <= w_waddr_nx;
         r_wlen      <= w_wlen_nx;
         r_wsize     <= w_wsize_nx;
         r_wcnt      <= w_wcnt_nx;
         r_werr      <= w_werr_nx;
         r_wlast_err <= w_wlast_err_nx;
      end
   end

   // ---------------- read channel ----------------
   r_state_t              r_r_state, w_r_state_nx;
   logic                  r_arready, w_arready_nx;
   logic                  r_rvalid,  w_rvalid_nx;
   logic                  r_rlast,   w_rlast_nx;
   logic [1:0]            r_rresp,   w_rresp_nx;
   logic [ADDR_WIDTH-1:0] r_raddr,   w_raddr_nx;
   logic [7:0]            r_rlen,    w_rlen_nx;
   logic [2:0]            r_rsize,   w_rsize_nx;
   logic [7:0]            r_rcnt,    w_rcnt_nx;
   logic                  r_rerr,    w_rerr_nx;
   logic                  w_ar_err, w_mem_re;
   logic [ADDR_WIDTH-1:0] w_rd_byte;
   logic [DATA_WIDTH-1:0] w_ram_q;

   assign w_ar_err = burst_err(32'(ARADDR), ARLEN, ARSIZE, ADDR_LSB, MEMORY_DEPTH);

   // The next beat's word is fetched on the handshake edge, so RDATA only
   // changes when a beat is consumed and stays put while the master stalls.
   always_comb begin
      w_r_state_nx = r_r_state;
      w_arready_nx = r_arready;
      w_rvalid_nx  = r_rvalid;
      w_rlast_nx   = r_rlast;
      w_rresp_nx   = r_rresp;
      w_raddr_nx   = r_raddr;
      w_rlen_nx    = r_rlen;
      w_rsize_nx   = r_rsize;
      w_rcnt_nx    = r_rcnt;
      w_rerr_nx    = r_rerr;
      w_mem_re     = 1'b0;
      w_rd_byte    = r_raddr;
      case (r_r_state)
         R_IDLE: begin
            w_arready_nx = 1'b1;
            if (ARVALID && r_arready) begin
               w_raddr_nx   = ARADDR;
               w_rlen_nx    = ARLEN;
               w_rsize_nx   = ARSIZE;
               w_rerr_nx    = w_ar_err;
               w_rcnt_nx    = 8'd0;
               w_rvalid_nx  = 1'b1;
               w_rlast_nx   = (ARLEN == 8'd0);
               w_rresp_nx   = w_ar_err ? RESP_SLVERR : RESP_OKAY;
               w_arready_nx = 1'b0;
               w_mem_re     = !w_ar_err;
               w_rd_byte    = ARADDR;
               w_r_state_nx = R_DATA;
            end
         end
         R_DATA: begin
            if (r_rvalid && RREADY) begin
               if (r_rcnt == r_rlen) begin
                  w_rvalid_nx  = 1'b0;
                  w_rlast_nx   = 1'b0;
                  w_arready_nx = 1'b1;
                  w_r_state_nx = R_IDLE;
               end else begin
                  w_rcnt_nx  = r_rcnt + 8'd1;
                  w_raddr_nx = r_raddr + (ONE << r_rsize);
                  w_rd_byte  = w_raddr_nx;
                  w_mem_re   = !r_rerr;
                  w_rlast_nx = ((r_rcnt + 8'd1) == r_rlen);
               end
            end
         end
         default: w_r_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_r_state <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_raddr   <= '0;
         r_rlen    <= '0;
         r_rsize   <= '0;
         r_rcnt    <= '0;
         r_rerr    <= 1'b0;
      end else begin
         r_r_state <= w_r_state_nx;
         r_arready <= w_arready_nx;
         r_rvalid  <= w_rvalid_nx;
         r_rlast   <= w_rlast_nx;
         r_rresp   <= w_rresp_nx;
         r_raddr   <= w_raddr_nx;
         r_rlen    <= w_rlen_nx;
         r_rsize   <= w_rsize_nx;
         r_rcnt    <= w_rcnt_nx;
         r_rerr    <= w_rerr_nx;
      end
   end

   axi4_slave_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEMORY_DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_we    (w_mem_we),
      .i_waddr (r_waddr[ADDR_LSB +: IDX_W]),
      .i_wdata (WDATA),
      .i_re    (w_mem_re),
      .i_raddr (w_rd_byte[ADDR_LSB +: IDX_W]),
      .o_rdata (w_ram_q)
   );

   assign AWREADY = r_awready;
   assign WREADY  = r_wready;
   assign BVALID  = r_bvalid;
   assign BRESP   = r_bresp;
   assign ARREADY = r_arready;
   assign RVALID  = r_rvalid;
   assign RLAST   = r_rlast;
   assign RRESP   = r_rresp;
   assign RDATA   = r_rerr ? '0 : w_ram_q;

endmodule

// File: doc/axi4_mem_slave.md
Name: axi4_mem_slave

Overview:
AXI4 memory-mapped slave that backs a word-organised RAM and answers INCR write and read bursts from an AXI4 master. It is the responder end of the `arb_if` bus, and the `axi4_tb` driver and golden models target it. Bursts that fall outside the memory or cross a 4 KB boundary are consumed in full and answered with SLVERR. Write and read channels run independently and concurrently.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; one memory word = DATA_WIDTH/8 bytes.
- ADDR_WIDTH, 16, byte-address width.
- MEMORY_DEPTH, 1024, number of memory words.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write burst start byte address.
- AWLEN  in  8  write beats minus 1.
- AWSIZE  in  3  log2 bytes per beat.
- AWVALID / AWREADY  in / out  1  write address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WVALID  in  1  write data valid.
- WLAST  in  1  last write beat marker.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write response handshake.
- ARADDR  in  ADDR_WIDTH  read burst start byte address.
- ARLEN  in  8  read beats minus 1.
- ARSIZE  in  3  log2 bytes per beat.
- ARVALID / ARREADY  in / out  1  read address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat marker.
- RVALID / RREADY  out / in  1  read data handshake.

Behaviour:
- Reset (async, ARESETn=0):
  - All outputs 0: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, RLAST.
  - Both FSMs return to IDLE, including mid-burst; a partially received burst is abandoned and no response is issued.
  - Memory contents are not cleared.
  - AWREADY and ARREADY rise on the first clock edge after release.
- Addressing:
  - Word index = addr >> log2(DATA_WIDTH/8).
  - Per-beat address increments by 2**AxSIZE bytes; INCR bursts only.
  - Every beat writes or reads the full word.
- Error check, evaluated at address handshake; err when either holds:
  - (start word index + LEN + 1) > MEMORY_DEPTH, or
  - (addr mod 4096) + (LEN+1)*2**SIZE > 4096.
  - Error response = SLVERR 2'b10; otherwise OKAY 2'b00.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch address, length, size and err, then go to W_DATA with AWREADY=0 and WREADY=1.
  - W_DATA: each WVALID&&WREADY beat writes memory unless err, then increments the beat counter.
  - The beat where counter==LEN ends the burst: WREADY=0, go to W_RESP.
  - WLAST mismatch (asserted early or missing on the final beat) forces BRESP=SLVERR; the burst length is still governed by LEN.
  - W_RESP: BVALID=1 with BRESP held stable until BREADY, then back to W_IDLE with AWREADY=1 on the next cycle.
- Read FSM:
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch fields and err, issue the memory read of beat 0, go to R_DATA.
  - R_DATA: RVALID=1 one cycle after the AR handshake.
  - RDATA, RRESP and RLAST stay stable while RVALID&&!RREADY.
  - On each RVALID&&RREADY that is not the last beat, the next word is registered into RDATA, so back-to-back RREADY gives 1 beat/cycle.
  - RLAST=1 only on beat LEN.
  - On the last handshake: RVALID=0, RLAST=0, back to R_IDLE.
  - Error bursts return LEN+1 beats with RDATA=0 and RRESP=SLVERR; memory is not accessed.
- Concurrency:
  - A write and a read to the same word in the same cycle return the pre-write data.
  - The channels never stall each other.
- Width rules:
  - Beat counters are 8 bits; the beat-count sum (start word index + LEN + 1) is computed at ADDR_WIDTH+1 bits to avoid wrap.
  - AxSIZE > log2(DATA_WIDTH/8) is treated as err.

Decomposition:
- Package axi_slave_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write FSM enum {W_IDLE, W_DATA, W_RESP}.
  - Read FSM enum {R_IDLE, R_DATA}.
  - 4 KB boundary constant BOUNDARY_BYTES=4096.
- Sub-module axi4_slave_ram: simple dual-port RAM of MEMORY_DEPTH x DATA_WIDTH with one write port and one registered read port (read-before-write).
- Top module contains both FSMs and the error-check logic.

Test Plan:
- Reset, then write AWADDR=0x0010, AWLEN=3, AWSIZE=2, data A0..A3 -> 4 WREADY handshakes, BVALID with BRESP=00; read ARADDR=0x0010, ARLEN=3 -> RDATA A0,A1,A2,A3 with RLAST on the 4th beat, RRESP=00.
- Write AWADDR=0x1000 (word 1024), AWLEN=0 -> data accepted, BRESP=10; memory unchanged; read ARADDR=0x0FFC, ARLEN=1 -> 2 beats RDATA=0, RRESP=10, RLAST on beat 2.
- Read ARADDR=0x0FF8, ARLEN=3, ARSIZE=2 (crosses 4 KB) -> 4 beats, RRESP=10.
- Read with RREADY toggling 1,0,0,1 -> RDATA/RLAST held stable while stalled; no beat lost or duplicated.
- Concurrent write to word 5 and read of word 5 in the same cycle -> read returns the old value; a subsequent read returns the new value.
- Deassert ARESETn mid write burst (beat 2 of 4) -> all outputs 0 immediately; after release AWREADY=1; a new burst completes with BRESP=00.
